data_mem_ls: RTL and testbench

- Parametrised successor to the core's byte-array data memory.
- Adds MIPS load/store sizing (lb/lbu/lh/lhu/lw/sb/sh/sw) and big-endian byte lanes.
- Adds alignment and range checking, plus a configurable access latency with a stall handshake to the pipeline.
- Sits in the MEM stage between the ALU result / rt operand and the writeback mux.

---
 rtl/data_mem_ls.sv | 195 +++++++++++++++++++
 tb/tb_data_mem_ls.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ls.sv
// MEM-stage byte-array data memory with MIPS load/store sizing, big-endian lanes,
// alignment/range checking and a LATENCY-cycle stall handshake. DMEM_PERF_CNT_EN adds access counters.
module data_mem_ls #(
    parameter int DEPTH_BYTES = 2048,
    parameter int ADDR_WIDTH  = 32,
    parameter int LATENCY     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            ls_size,
    input  logic                  ls_unsigned,
    input  logic [ADDR_WIDTH-1:0] dmem_address,
    input  logic [31:0]           write_data_mem,
    output logic [31:0]           read_data,
    output logic                  rd_valid,
    output logic                  stall,
`ifdef DMEM_PERF_CNT_EN
    output logic [31:0]           load_cnt,
    output logic [31:0]           store_cnt,
    output logic [31:0]           err_cnt,
`endif
    output logic                  mem_err
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit MULTI = (LATENCY > 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Handshake: stall high means the pipeline holds MemRead/MemWrite and operands;
    // the access executes on the first rising edge at which stall is low.

    logic [0:0]            state;
    logic [CNT_W-1:0]      cnt;

    logic                  q_write;
    logic [1:0]            q_size;
    logic                  q_unsigned;
    logic [ADDR_WIDTH-1:0] q_addr;
    logic [31:0]           q_wdata;

    logic [7:0]            mem [DEPTH_BYTES];

    logic                  req;
    logic                  x_fire;
    logic                  x_write;
    logic [1:0]            x_size;
    logic                  x_unsigned;
    logic [ADDR_WIDTH-1:0] x_addr;
    logic [31:0]           x_wdata;
    logic                  x_err;
    logic [2:0]            nbytes_m1;
    logic [ADDR_WIDTH:0]   last_addr;
    logic [IDX_W-1:0]      i0, i1, i2, i3;
    logic [31:0]           load_val;
    logic                  do_load;
    logic                  do_store;

    assign req = MemRead | MemWrite;

    // The executing access comes straight from the ports when single-cycle,
    // otherwise from the request latched on entry to BUSY.
    always_comb begin
        x_fire     = req && !MULTI && (state == IDLE);
        x_write    = MemWrite;
        x_size     = ls_size;
        x_unsigned = ls_unsigned;
        x_addr     = dmem_address;
        x_wdata    = write_data_mem;
        if (state == BUSY) begin
            x_fire     = (cnt == CNT_W'(1));
            x_write    = q_write;
            x_size     = q_size;
            x_unsigned = q_unsigned;
            x_addr     = q_addr;
            x_wdata    = q_wdata;
        end
    end

    always_comb begin
        stall = MULTI && (((state == IDLE) && req) || ((state == BUSY) && (cnt > CNT_W'(1))));
    end

    always_comb begin
        case (x_size)
            2'b00:   nbytes_m1 = 3'd0;
            2'b01:   nbytes_m1 = 3'd1;
            2'b10:   nbytes_m1 = 3'd3;
            default: nbytes_m1 = 3'd0;
        endcase
        last_addr = {1'b0, x_addr} + {{(ADDR_WIDTH-2){1'b0}}, nbytes_m1};
        x_err = (x_size == 2'b11)
             || ((x_size == 2'b01) && x_addr[0])
             || ((x_size == 2'b10) && (x_addr[1:0] != 2'b00))
             || (last_addr >= (ADDR_WIDTH+1)'(DEPTH_BYTES));
    end

    assign i0 = x_addr[IDX_W-1:0];
    assign i1 = i0 + IDX_W'(1);
    assign i2 = i0 + IDX_W'(2);
    assign i3 = i0 + IDX_W'(3);

    always_comb begin
        case (x_size)
            2'b00:   load_val = x_unsigned ? {24'd0, mem[i0]} : {{24{mem[i0][7]}}, mem[i0]};
            2'b01:   load_val = x_unsigned ? {16'd0, mem[i0], mem[i1]}
                                           : {{16{mem[i0][7]}}, mem[i0], mem[i1]};
            default: load_val = {mem[i0], mem[i1], mem[i2], mem[i3]};
        endcase
    end

    assign do_load  = x_fire && !x_write && !x_err;
    assign do_store = x_fire &&  x_write && !x_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            read_data  <= '0;
            rd_valid   <= 1'b0;
            mem_err    <= 1'b0;
            q_write    <= 1'b0;
            q_size     <= '0;
            q_unsigned <= 1'b0;
            q_addr     <= '0;
            q_wdata    <= '0;
        end else begin
            rd_valid <= do_load;
            mem_err  <= x_fire && x_err;
            if (do_load) begin
                read_data <= load_val;
            end
            case (state)
                IDLE: begin
                    if (req && MULTI) begin
                        state      <= BUSY;
                        cnt        <= CNT_W'(LATENCY - 1);
                        q_write    <= MemWrite;
                        q_size     <= ls_size;
                        q_unsigned <= ls_unsigned;
                        q_addr     <= dmem_address;
                        q_wdata    <= write_data_mem;
                    end
                end
                default: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH_BYTES; k++) begin
                mem[k] <= 8'd0;
            end
        end else if (do_store) begin
            case (x_size)
                2'b00: mem[i0] <= x_wdata[7:0];
                2'b01: begin
                    mem[i0] <= x_wdata[15:8];
                    mem[i1] <= x_wdata[7:0];
                end
                default: begin
                    mem[i0] <= x_wdata[31:24];
                    mem[i1] <= x_wdata[23:16];
                    mem[i2] <= x_wdata[15:8];
                    mem[i3] <= x_wdata[7:0];
                end
            endcase
        end
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (do_load)         load_cnt  <= load_cnt + 32'd1;
            if (do_store)        store_cnt <= store_cnt + 32'd1;
            if (x_fire && x_err) err_cnt   <= err_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_ls.sv
// Bench for data_mem_ls: one instance at LATENCY=1 (index 0) and one at LATENCY=3 (index 1),
// checked against a byte-array model of the load/store rules.
module tb_data_mem_ls;

    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s [2];
    logic        mr    [2];
    logic        mw    [2];
    logic        uns   [2];
    logic [1:0]  sz    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        rv    [2];
    logic        stl   [2];
    logic        err   [2];
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] lc [2];
    logic [31:0] sc [2];
    logic [31:0] ec [2];
`endif

    data_mem_ls #(.DEPTH_BYTES(DEPTH), .ADDR_WIDTH(32), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst_s[0]), .MemRead(mr[0]), .MemWrite(mw[0]),
        .ls_size(sz[0]), .ls_unsigned(uns[0]), .dmem_address(addr[0]),
        .write_data_mem(wd[0]), .read_data(rdata[0]), .rd_valid(rv[0]),
        .stall(stl[0]),
`ifdef DMEM_PERF_CNT_EN
        .load_cnt(lc[0]), .store_cnt(sc[0]), .err_cnt(ec[0]),
`endif
        .mem_err(err[0])
    );

    data_mem_ls #(.DEPTH_BYTES(DEPTH), .ADDR_WIDTH(32), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst_s[1]), .MemRead(mr[1]), .MemWrite(mw[1]),
        .ls_size(sz[1]), .ls_unsigned(uns[1]), .dmem_address(addr[1]),
        .write_data_mem(wd[1]), .read_data(rdata[1]), .rd_valid(rv[1]),
        .stall(stl[1]),
`ifdef DMEM_PERF_CNT_EN
        .load_cnt(lc[1]), .store_cnt(sc[1]), .err_cnt(ec[1]),
`endif
        .mem_err(err[1])
    );

    // Reference model
    logic [7:0]  mdl_mem [2][DEPTH];
    logic [31:0] mdl_rd  [2];
    int          mdl_loads [2];
    int          mdl_stores [2];
    int          mdl_errs [2];

    int tests = 0;
    int fails = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic model_reset(input int d);
        for (int k = 0; k < DEPTH; k++) mdl_mem[d][k] = 8'd0;
        mdl_rd[d]     = 32'd0;
        mdl_loads[d]  = 0;
        mdl_stores[d] = 0;
        mdl_errs[d]   = 0;
    endtask

    task automatic model_access(input int d, input bit wr, input logic [1:0] s, input bit u,
                                input logic [31:0] a, input logic [31:0] w,
                                output bit e, output bit v);
        int     n;
        longint val;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        e = (s == 2'd3) || ((a % n) != 0) || ((longint'(a) + n) > DEPTH);
        v = 1'b0;
        if (e) begin
            mdl_errs[d]++;
        end else if (wr) begin
            for (int k = 0; k < n; k++) mdl_mem[d][a + k] = 8'(w >> (8 * (n - 1 - k)));
            mdl_stores[d]++;
        end else begin
            val = 0;
            for (int k = 0; k < n; k++) val = val * 256 + mdl_mem[d][a + k];
            if (!u && n < 4 && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
            mdl_rd[d] = val[31:0];
            v = 1'b1;
            mdl_loads[d]++;
        end
    endtask

    task automatic idle_inputs(input int d);
        mr[d] = 1'b0; mw[d] = 1'b0; sz[d] = 2'd0; uns[d] = 1'b0; addr[d] = 32'd0; wd[d] = 32'd0;
    endtask

    task automatic do_reset(input int d);
        rst_s[d] = 1'b1;
        idle_inputs(d);
        @(negedge clk);
        @(negedge clk);
        rst_s[d] = 1'b0;
        model_reset(d);
    endtask

    // Starts and ends at a falling edge; inputs are dropped at the end so a following
    // call presents its request in the very next cycle.
    task automatic access(input int d, input bit rd, input bit wr, input logic [1:0] s, input bit u,
                          input logic [31:0] a, input logic [31:0] w, input string name);
        int stall_cycles;
        bit e, v;
        mr[d] = rd; mw[d] = wr; sz[d] = s; uns[d] = u; addr[d] = a; wd[d] = w;
        #1;
        stall_cycles = 0;
        while (stl[d] === 1'b1 && stall_cycles < 10) begin
            stall_cycles++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        model_access(d, wr, s, u, a, w, e, v);
        tests++;
        if (stall_cycles != lat_of(d) - 1) begin
            fails++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, lat_of(d) - 1);
        end
        tests++;
        if (err[d] !== e) begin
            fails++;
            $display("FAIL %s mem_err: got %b expected %b", name, err[d], e);
        end
        tests++;
        if (rv[d] !== v) begin
            fails++;
            $display("FAIL %s rd_valid: got %b expected %b", name, rv[d], v);
        end
        tests++;
        if (rdata[d] !== mdl_rd[d]) begin
            fails++;
            $display("FAIL %s read_data: got %h expected %h", name, rdata[d], mdl_rd[d]);
        end
        mr[d] = 1'b0;
        mw[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_s[0] = 1'b1; rst_s[1] = 1'b1;
        idle_inputs(0); idle_inputs(1);
        repeat (3) @(negedge clk);
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        model_reset(0); model_reset(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (rdata[d] !== 32'd0 || rv[d] !== 1'b0 || stl[d] !== 1'b0 || err[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_outputs[%0d]: got rd=%h v=%b s=%b e=%b expected all 0",
                         d, rdata[d], rv[d], stl[d], err[d]);
            end
        end
        @(negedge clk);
        access(0, 1, 0, 2'd2, 0, 32'h10, 32'd0, "reset_lw_zero");
    endtask

    task automatic test_lat1_directed();
        access(0, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, "sw_10");
        access(0, 1, 0, 2'd2, 0, 32'h10, 32'd0, "lw_10");
        tests++;
        if (rdata[0] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL lw_10_const: got %h expected %h", rdata[0], 32'hDEADBEEF);
        end
        access(0, 1, 0, 2'd0, 0, 32'h10, 32'd0, "lb_10");
        tests++;
        if (rdata[0] !== 32'hFFFFFFDE) begin
            fails++; $display("FAIL lb_10_const: got %h expected %h", rdata[0], 32'hFFFFFFDE);
        end
        access(0, 1, 0, 2'd0, 1, 32'h13, 32'd0, "lbu_13");
        tests++;
        if (rdata[0] !== 32'h000000EF) begin
            fails++; $display("FAIL lbu_13_const: got %h expected %h", rdata[0], 32'h000000EF);
        end
        access(0, 1, 0, 2'd1, 0, 32'h12, 32'd0, "lh_12");
        tests++;
        if (rdata[0] !== 32'hFFFFBEEF) begin
            fails++; $display("FAIL lh_12_const: got %h expected %h", rdata[0], 32'hFFFFBEEF);
        end
        access(0, 1, 0, 2'd1, 1, 32'h10, 32'd0, "lhu_10");
        tests++;
        if (rdata[0] !== 32'h0000DEAD) begin
            fails++; $display("FAIL lhu_10_const: got %h expected %h", rdata[0], 32'h0000DEAD);
        end
        access(0, 0, 1, 2'd0, 0, 32'h11, 32'h12345655, "sb_11");
        access(0, 1, 0, 2'd2, 1, 32'h10, 32'd0, "lw_after_sb");
        tests++;
        if (rdata[0] !== 32'hDE55BEEF) begin
            fails++; $display("FAIL lw_after_sb_const: got %h expected %h", rdata[0], 32'hDE55BEEF);
        end
    endtask

    task automatic test_errors();
        access(0, 1, 0, 2'd2, 0, 32'h12, 32'd0, "lw_misaligned");
        access(0, 1, 0, 2'd1, 0, 32'h13, 32'd0, "lh_misaligned");
        access(0, 0, 1, 2'd2, 0, 32'h7FE, 32'hCAFEF00D, "sw_7fe");
        access(0, 0, 1, 2'd2, 0, 32'h7FC, 32'h01020304, "sw_7fc_ok");
        access(0, 0, 1, 2'd0, 0, 32'h800, 32'h000000AA, "sb_800_range");
        access(0, 1, 0, 2'd0, 1, 32'h0001_07FF, 32'd0, "lbu_highbit_range");
        access(0, 1, 0, 2'd3, 0, 32'h10, 32'd0, "size_11_load");
        access(0, 0, 1, 2'd3, 0, 32'h20, 32'hFFFFFFFF, "size_11_store");
        access(0, 1, 0, 2'd2, 0, 32'h7FC, 32'd0, "lw_7fc");
        access(0, 1, 0, 2'd2, 0, 32'h20, 32'd0, "lw_20_untouched");
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            access(d, 0, 1, 2'd2, 0, 32'h40, 32'hA1B2C3D4, "b2b_sw");
            access(d, 1, 0, 2'd2, 0, 32'h40, 32'd0, "b2b_lw");
            access(d, 1, 1, 2'd1, 0, 32'h42, 32'h00009988, "b2b_both_is_store");
            access(d, 1, 0, 2'd1, 1, 32'h42, 32'd0, "b2b_lhu");
            @(negedge clk);
            tests++;
            if (rv[d] !== 1'b0 || err[d] !== 1'b0) begin
                fails++;
                $display("FAIL pulse_width[%0d]: got v=%b e=%b expected 0 0", d, rv[d], err[d]);
            end
        end
    endtask

    task automatic test_latency3();
        bit e, v;
        mr[1] = 1'b0; mw[1] = 1'b1; sz[1] = 2'd2; uns[1] = 1'b0; addr[1] = 32'h80; wd[1] = 32'h11223344;
        #1;
        tests++;
        if (stl[1] !== 1'b1) begin fails++; $display("FAIL lat3_stall_c0: got %b expected 1", stl[1]); end
        @(negedge clk);
        // Changed inputs while BUSY must not affect the latched store.
        addr[1] = 32'h84; wd[1] = 32'h55667788;
        #1;
        tests++;
        if (stl[1] !== 1'b1) begin fails++; $display("FAIL lat3_stall_c1: got %b expected 1", stl[1]); end
        @(negedge clk);
        #1;
        tests++;
        if (stl[1] !== 1'b0) begin fails++; $display("FAIL lat3_stall_c2: got %b expected 0", stl[1]); end
        @(negedge clk);
        idle_inputs(1);
        model_access(1, 1, 2'd2, 0, 32'h80, 32'h11223344, e, v);
        tests++;
        if (err[1] !== 1'b0 || rv[1] !== 1'b0) begin
            fails++; $display("FAIL lat3_sw_done: got e=%b v=%b expected 0 0", err[1], rv[1]);
        end
        access(1, 1, 0, 2'd2, 0, 32'h80, 32'd0, "lat3_lw_80");
        access(1, 1, 0, 2'd2, 0, 32'h84, 32'd0, "lat3_lw_84");
        access(1, 1, 0, 2'd2, 0, 32'h81, 32'd0, "lat3_lw_err");
    endtask

    task automatic test_reset_busy();
        mr[1] = 1'b0; mw[1] = 1'b1; sz[1] = 2'd2; uns[1] = 1'b0; addr[1] = 32'h90; wd[1] = 32'hFEEDFACE;
        @(negedge clk);
        @(negedge clk);
        rst_s[1] = 1'b1;
        idle_inputs(1);
        @(negedge clk);
        rst_s[1] = 1'b0;
        model_reset(1);
        #1;
        tests++;
        if (stl[1] !== 1'b0 || rdata[1] !== 32'd0 || rv[1] !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy_outputs: got s=%b rd=%h v=%b expected 0 0 0", stl[1], rdata[1], rv[1]);
        end
        @(negedge clk);
        access(1, 1, 0, 2'd2, 0, 32'h90, 32'd0, "reset_busy_lw");
        access(1, 1, 0, 2'd2, 0, 32'h10, 32'd0, "reset_busy_cleared");
    endtask

    task automatic test_random(input int d, input int nops);
        logic [1:0]  s;
        logic [31:0] a;
        bit          wr, rd, u;
        int          n, r;
        for (int i = 0; i < nops; i++) begin
            r = $urandom_range(0, 7);
            s = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
            n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, 63));
                2:       a = 32'($urandom_range(2040, 2047));
                default: a = 32'($urandom_range(0, 63)) | (32'd1 << $urandom_range(11, 31));
            endcase
            if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            wr = ($urandom_range(0, 2) == 0);
            rd = !wr || ($urandom_range(0, 1) == 1);
            u  = $urandom_range(0, 1);
            access(d, rd, wr, s, u, a, $urandom, "random");
        end
`ifdef DMEM_PERF_CNT_EN
        tests++;
        if (lc[d] !== 32'(mdl_loads[d]) || sc[d] !== 32'(mdl_stores[d]) || ec[d] !== 32'(mdl_errs[d])) begin
            fails++;
            $display("FAIL random_perf[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", d,
                     lc[d], sc[d], ec[d], mdl_loads[d], mdl_stores[d], mdl_errs[d]);
        end
`endif
    endtask

`ifdef DMEM_PERF_CNT_EN
    task automatic test_perf();
        do_reset(0);
        access(0, 0, 1, 2'd2, 0, 32'h20, 32'h89ABCDEF, "perf_sw");
        access(0, 1, 0, 2'd2, 0, 32'h20, 32'd0, "perf_lw");
        access(0, 1, 0, 2'd1, 0, 32'h22, 32'd0, "perf_lh");
        access(0, 1, 0, 2'd2, 0, 32'h21, 32'd0, "perf_err");
        tests++;
        if (lc[0] !== 32'd2 || sc[0] !== 32'd1 || ec[0] !== 32'd1) begin
            fails++;
            $display("FAIL perf_counts: got %0d/%0d/%0d expected 2/1/1", lc[0], sc[0], ec[0]);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lat1_directed();
        test_errors();
        test_back_to_back();
        test_latency3();
        test_reset_busy();
        test_random(0, 150);
        test_random(1, 150);
`ifdef DMEM_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
